// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_t   - loader FSM states
//   OPC_W     - opcode width
//   K_W       - K field width
//   INSTR_W   - instruction word width (opcode + K)
//   MAX_WORDS - word count encoded by a COUNT byte of 0
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int OPC_W     = 7;
  localparam int K_W       = 8;
  localparam int INSTR_W   = OPC_W + K_W;
  localparam int MAX_WORDS = 256;

endpackage

// File: rtl/prog_loader_xsum.sv
// prog_loader_xsum: 8-bit XOR accumulator over accepted stream bytes.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   clear      - zero the accumulator (takes priority over accept)
//   accept     - fold data into the accumulator this cycle
//   data       - stream byte
//   sum        - running XOR of all bytes accepted since the last clear
module prog_loader_xsum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte stream (COUNT, then HI/LO pairs) into
// instruction memory starting at address 0 and releases the CPU when done.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over COUNT, HI and LO bytes before releasing the CPU.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   in_valid/in_data  - byte stream in; in_ready - byte accepted this cycle
//   load_start        - restart pulse, honoured only in DONE or ERR
//   im_we/im_addr/im_wdata - instruction memory write port
//   cpu_run           - CPU released
//   error             - sticky framing/checksum error
//   loaded_count      - words written in the current load
//
// state | meaning
// IDLE  | waiting for COUNT byte
// HI    | waiting for opcode byte (bit 7 must be 0)
// LO    | waiting for K byte
// WRITE | one-cycle memory write of assembled word
// CHK   | waiting for checksum byte (checksum build only)
// DONE  | image loaded, CPU running
// ERR   | framing or checksum error, CPU held
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               load_start,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_run,
  output logic               error,
  output logic [ADDR_W:0]    loaded_count
);

  import prog_loader_pkg::*;

  localparam int REM_W = ADDR_W + 1;

  state_t             state;
  logic [REM_W-1:0]   remaining;
  logic [ADDR_W-1:0]  addr;
  logic [OPC_W-1:0]   opcode;
  logic               accept;
  logic [REM_W-1:0]   rem_init;
  logic               restart;

  assign in_ready = (state == IDLE) || (state == HI) ||
                    (state == LO)   || (state == CHK);
  assign im_we    = (state == WRITE);
  assign accept   = in_valid && in_ready;
  assign restart  = load_start && ((state == DONE) || (state == ERR));
  // A COUNT of 0 stands for a full 256-word image.
  assign rem_init = (in_data == 8'd0) ? REM_W'(MAX_WORDS) : REM_W'(in_data);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] xsum;

  // Restart is the only way back into IDLE after reset, so it doubles as
  // the accumulator clear; the checksum byte itself is never folded in.
  prog_loader_xsum u_xsum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (restart),
    .accept (accept && (state != CHK)),
    .data   (in_data),
    .sum    (xsum)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      addr         <= '0;
      opcode       <= '0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_run      <= 1'b0;
      error        <= 1'b0;
      loaded_count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          remaining <= rem_init;
          addr      <= '0;
          state     <= HI;
        end
        HI: if (accept) begin
          if (in_data[7]) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            opcode <= in_data[OPC_W-1:0];
            state  <= LO;
          end
        end
        LO: if (accept) begin
          im_wdata <= {opcode, in_data};
          im_addr  <= addr;
          state    <= WRITE;
        end
        WRITE: begin
          addr         <= addr + 1'b1;
          remaining    <= remaining - 1'b1;
          loaded_count <= loaded_count + 1'b1;
          if (remaining == REM_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            cpu_run <= 1'b1;
            state   <= DONE;
`endif
          end else begin
            state <= HI;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: if (accept) begin
          if (in_data == xsum) begin
            cpu_run <= 1'b1;
            state   <= DONE;
          end else begin
            error <= 1'b1;
            state <= ERR;
          end
        end
`endif
        DONE, ERR: if (restart) begin
          cpu_run      <= 1'b0;
          error        <= 1'b0;
          loaded_count <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stimulus for prog_loader checked against a
// frame-level reference model (expected write list, outcome, byte usage).
// Define PROG_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        load_start = 1'b0;
  logic        in_ready, im_we, cpu_run, error;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic [8:0]  loaded_count;

  prog_loader #(.ADDR_W(8), .INSTR_W(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .load_start   (load_start),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_run      (cpu_run),
    .error        (error),
    .loaded_count (loaded_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write/ready monitor, sampled mid-cycle.
  int          cyc = 0;
  logic [22:0] wr_q[$];
  int          ready_viol = 0;
  int          last_we_cyc = -1;
  int          run_rise_cyc = -1;
  logic        run_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (im_we === 1'b1) begin
      wr_q.push_back({im_addr, im_wdata});
      last_we_cyc = cyc;
      if (in_ready !== 1'b0) ready_viol++;
    end
    if (cpu_run === 1'b1 && run_d !== 1'b1) run_rise_cyc = cyc;
    run_d = cpu_run;
  end

  // Reference model: frame bytes -> expected writes, outcome, bytes consumed.
  logic [7:0]  frame[$];
  logic [22:0] exp_q[$];
  bit          exp_ok;
  int          exp_used;

  task automatic run_model();
    int n;
    logic [7:0] hi, lo, x;
    exp_q.delete();
    x        = frame[0];
    n        = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
    exp_used = 1;
    exp_ok   = 1'b1;
    for (int i = 0; i < n; i++) begin
      hi = frame[1 + 2*i];
      exp_used++;
      if (hi[7]) begin
        exp_ok = 1'b0;
        return;
      end
      lo = frame[2 + 2*i];
      exp_used++;
      x = x ^ hi ^ lo;
      exp_q.push_back({8'(i % 256), hi[6:0], lo});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_used++;
    exp_ok = (frame[exp_used-1] == x);
`endif
  endtask

  task automatic add_chk(input bit bad);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(bad ? (x ^ 8'h01) : x);
`else
    if (bad) frame.push_back(8'h00);
`endif
  endtask

  task automatic make_frame(input int n, input int err_at, input bit bad_chk);
    logic [7:0] hi;
    frame.delete();
    frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom) & 8'h7F;
      if (i == err_at) hi = hi | 8'h80;
      frame.push_back(hi);
      frame.push_back(8'($urandom));
    end
    add_chk(bad_chk);
  endtask

  // mode 0: continuous valid, 1: alternating, 2: random 50%
  task automatic send(input int nbytes, input int mode);
    int idx = 0;
    int budget = 0;
    bit acc;
    bit tog = 1'b0;
    while (idx < nbytes) begin
      @(negedge clk);
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin tog = ~tog; in_valid = tog; end
        default: in_valid = ($urandom_range(99) < 50);
      endcase
      in_data = in_valid ? frame[idx] : 8'($urandom);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      budget++;
      if (budget > 5000) begin
        check("send_timeout", idx, nbytes);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    ready_viol   = 0;
    last_we_cyc  = -1;
    run_rise_cyc = -1;
  endtask

  task automatic load_and_check(input string tag, input int mode);
    run_model();
    clear_mon();
    check({tag, "_ready_idle"}, in_ready, 1);
    send(exp_used, mode);
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < wr_q.size()) check({tag, "_write"}, wr_q[i], exp_q[i]);
    check({tag, "_error"}, error, !exp_ok);
    check({tag, "_cpu_run"}, cpu_run, exp_ok);
    check({tag, "_loaded_count"}, loaded_count, exp_q.size());
    check({tag, "_ready_in_write"}, ready_viol, 0);
    check({tag, "_ready_after"}, in_ready, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
    if (exp_ok) check({tag, "_run_latency"}, run_rise_cyc - last_we_cyc, 1);
`endif
  endtask

  task automatic restart();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("restart_error", error, 0);
    check("restart_cpu_run", cpu_run, 0);
    check("restart_count", loaded_count, 0);
    check("restart_ready", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_im_we"}, im_we, 0);
    check({tag, "_im_addr"}, im_addr, 0);
    check({tag, "_im_wdata"}, im_wdata, 0);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_count"}, loaded_count, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two-word directed frame, continuous valid.
    frame = '{8'h02, 8'h05, 8'h3C, 8'h0A, 8'hFF};
    add_chk(1'b0);
    load_and_check("two_word", 0);
    if (wr_q.size() == 2) begin
      check("two_word_w0", wr_q[0], {8'h00, 15'h053C});
      check("two_word_w1", wr_q[1], {8'h01, 15'h0AFF});
    end else begin
      check("two_word_size", wr_q.size(), 2);
    end

    restart();
    load_and_check("two_word_alt", 1);

    restart();
    frame = '{8'h01, 8'h85, 8'h00};
    load_and_check("bad_hi", 0);

    restart();
    make_frame(3, -1, 1'b0);
    load_and_check("after_err", 2);

    restart();
    make_frame(256, -1, 1'b0);
    load_and_check("full_256", 0);

    for (int t = 0; t < 4; t++) begin
      restart();
      make_frame($urandom_range(12, 1), -1, 1'b0);
      load_and_check("rand", t % 3);
    end

    restart();
    make_frame(6, $urandom_range(5), 1'b0);
    load_and_check("rand_err", 2);

    // Reset asserted while the 3rd word is in WRITE.
    restart();
    make_frame(5, -1, 1'b0);
    send(7, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    make_frame(4, -1, 1'b0);
    load_and_check("after_reset", 2);

`ifdef PROG_LOADER_CHECKSUM_EN
    restart();
    frame = '{8'h01, 8'h05, 8'h3C, 8'h38};
    load_and_check("chk_good", 0);
    check("chk_good_run", cpu_run, 1);
    restart();
    frame = '{8'h01, 8'h05, 8'h3C, 8'h39};
    load_and_check("chk_bad", 0);
    check("chk_bad_err", error, 1);
    restart();
    make_frame(5, -1, 1'b1);
    load_and_check("chk_rand_bad", 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
